// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
// Contents: bus payload widths, the cdb_t payload struct, and rr_next,
//           the wrapped increment used for round-robin pointers.
package cdb_arbiter_pkg;

    localparam int unsigned RSV_ID_W = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    // Next pointer after winner w in an n-entry ring.
    function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
        return (w == n - 32'd1) ? 32'd0 : w + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above
// ptr, wrapping at N_REQ.
// Ports: req   - request vector
//        ptr   - search start index (0..N_REQ-1)
//        grant - one-hot winner
//        idx   - winner index
//        any   - at least one request set
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Explicit wrap keeps the candidate index inside 0..N_REQ-1 for any N_REQ.
    always_comb begin
        int unsigned c;
        c     = 32'd0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            c = 32'(ptr) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!any && req[ID_W'(c)]) begin
                any               = 1'b1;
                grant[ID_W'(c)]   = 1'b1;
                idx               = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per result producer and a
// round-robin pick that drives one registered result onto the CDB per cycle.
// Ports: clk, rst (sync, active-high)
//        req_valid/req_data/req_ready - per-requester result handshake
//        flush     - drop every pending result
//        cdb_valid/cdb/grant_id       - registered bus broadcast
//        busy      - any holding register occupied
// Build option: CDB_ARB_PRIO0_EN gives requester 0 absolute priority;
//               the others then share round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*CDB_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   flush,
    output logic                   cdb_valid,
    output logic [CDB_W-1:0]       cdb,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    logic [N_REQ-1:0] hold_valid;
    cdb_t             hold_data [N_REQ];
    logic [ID_W-1:0]  rr_ptr;

    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win;
    logic             any_grant;
    logic             ptr_adv;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef CDB_ARB_PRIO0_EN
    // Requester 0 overrides the ring and leaves the pointer untouched.
    assign pick_req = {hold_valid[N_REQ-1:1], 1'b0};

    always_comb begin
        grant     = pick_grant;
        win       = pick_idx;
        any_grant = pick_any;
        ptr_adv   = pick_any;
        if (hold_valid[0]) begin
            grant     = N_REQ'(1);
            win       = '0;
            any_grant = 1'b1;
            ptr_adv   = 1'b0;
        end
    end
`else
    assign pick_req  = hold_valid;
    assign grant     = pick_grant;
    assign win       = pick_idx;
    assign any_grant = pick_any;
    assign ptr_adv   = pick_any;
`endif

    // A granted entry always drains this cycle, so it may reload at once.
    assign req_ready = {N_REQ{~rst & ~flush}} & (~hold_valid | grant);
    assign busy      = |hold_valid;

    // Holding registers, pointer and bus output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                hold_data[i] <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb       <= '0;
            grant_id  <= '0;
        end else if (flush) begin
            hold_valid <= '0;
            cdb_valid  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= req_data[i*CDB_W +: CDB_W];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb      <= hold_data[win];
                grant_id <= win;
            end
            if (ptr_adv) begin
                rr_ptr <= ID_W'(rr_next(32'(win), N_REQ));
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: a 4-requester and a 3-requester instance run
// side by side against a queue-free behavioural model of pending results.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;

    logic             in_v [2][4];
    logic [CDB_W-1:0] in_d [2][4];

    logic [3:0]         v4;
    logic [4*CDB_W-1:0] bus4;
    logic [3:0]         r4;
    logic               cv4;
    logic [CDB_W-1:0]   cdb4;
    logic [1:0]         g4;
    logic               b4;

    logic [2:0]         v3;
    logic [3*CDB_W-1:0] bus3;
    logic [2:0]         r3;
    logic               cv3;
    logic [CDB_W-1:0]   cdb3;
    logic [1:0]         g3;
    logic               b3;

    int total = 0;
    int bad   = 0;

    // model state
    bit               m_hv  [2][4];
    logic [CDB_W-1:0] m_hd  [2][4];
    int               m_ptr [2];
    bit               m_cv  [2];
    logic [CDB_W-1:0] m_cdb [2];
    int               m_gid [2];
    logic [3:0]       exp_rdy [2];
    logic [3:0]       obs_rdy [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            v4[i] = in_v[0][i];
            bus4[i*CDB_W +: CDB_W] = in_d[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            v3[i] = in_v[1][i];
            bus3[i*CDB_W +: CDB_W] = in_d[1][i];
        end
    end

    cdb_arbiter #(.N_REQ(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_data(bus4), .req_ready(r4),
        .flush(flush), .cdb_valid(cv4), .cdb(cdb4), .grant_id(g4), .busy(b4)
    );

    cdb_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(bus3), .req_ready(r3),
        .flush(flush), .cdb_valid(cv3), .cdb(cdb3), .grant_id(g3), .busy(b3)
    );

    function automatic logic [CDB_W+3:0] exp_o(input int d);
        bit bz;
        bz = 1'b0;
        for (int i = 0; i < 4; i++) bz = bz | m_hv[d][i];
        return {m_cv[d], m_cdb[d], 2'(m_gid[d]), bz};
    endfunction

    function automatic logic [CDB_W+3:0] act_o(input int d);
        if (d == 0) return {cv4, cdb4, g4, b4};
        return {cv3, cdb3, g3, b3};
    endfunction

    function automatic logic [CDB_W-1:0] rnd_payload(input int tag);
        logic [CDB_W-1:0] p;
        p = {RSV_ID_W'(tag), DATA_W'($urandom)};
        return p;
    endfunction

    // Sample ready before the edge, advance the model one cycle, cross the edge.
    task automatic step();
        int n;
        int w;
        int c;
        logic [CDB_W-1:0] old;
        #1;
        obs_rdy[0] = r4;
        obs_rdy[1] = {1'b0, r3};
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 4 : 3;
            w = -1;
            if (PRIO && m_hv[d][0]) w = 0;
            for (int k = 0; k < n; k++) begin
                c = (m_ptr[d] + k) % n;
                if (w < 0 && !(PRIO && c == 0) && m_hv[d][c]) w = c;
            end
            exp_rdy[d] = '0;
            for (int i = 0; i < n; i++)
                exp_rdy[d][i] = !rst && !flush && (!m_hv[d][i] || w == i);
            old = (w >= 0) ? m_hd[d][w] : '0;
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_hv[d][i] = 1'b0;
                    m_hd[d][i] = '0;
                end
                m_ptr[d] = 0; m_cv[d] = 1'b0; m_cdb[d] = '0; m_gid[d] = 0;
            end else if (flush) begin
                for (int i = 0; i < 4; i++) m_hv[d][i] = 1'b0;
                m_cv[d] = 1'b0;
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (in_v[d][i] && exp_rdy[d][i]) begin
                        m_hv[d][i] = 1'b1;
                        m_hd[d][i] = in_d[d][i];
                    end else if (w == i) begin
                        m_hv[d][i] = 1'b0;
                    end
                end
                m_cv[d] = (w >= 0);
                if (w >= 0) begin
                    m_cdb[d] = old;
                    m_gid[d] = w;
                    if (!(PRIO && w == 0)) m_ptr[d] = (w + 1) % n;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int d, input bit v);
        for (int i = 0; i < 4; i++) begin
            in_v[d][i] = v;
            in_d[d][i] = rnd_payload($urandom_range(63));
        end
    endtask

    task automatic idle(input int cycles);
        set_all(0, 1'b0);
        set_all(1, 1'b0);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_all(0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs_rdy[0] !== 4'b0000) begin
                bad++; $display("FAIL reset_ready got=%b want=0000", obs_rdy[0]);
            end
            total++;
            if (act_o(0) !== exp_o(0) || cv4 !== 1'b0) begin
                bad++; $display("FAIL reset_out got=%h want=%h", act_o(0), exp_o(0));
            end
        end
        rst = 1'b0;
        step();
        total++;
        if (cv4 !== 1'b0 || b4 !== 1'b1) begin
            bad++; $display("FAIL reset_first_accept cv=%b busy=%b want cv=0 busy=1", cv4, b4);
        end
        set_all(0, 1'b0);
        step();
        total++;
        if (cv4 !== 1'b1 || g4 !== 2'd0 || act_o(0) !== exp_o(0)) begin
            bad++; $display("FAIL reset_first_grant got=%h want=%h", act_o(0), exp_o(0));
        end
    endtask

    task automatic test_single();
        idle(6);
        for (int k = 0; k < 5; k++) begin
            in_v[0][2] = (k < 3);
            in_d[0][2] = rnd_payload(5 + k);
            step();
            if (k < 3) begin
                total++;
                if (obs_rdy[0][2] !== 1'b1) begin
                    bad++; $display("FAIL single_ready k=%0d got=%b want=1", k, obs_rdy[0][2]);
                end
            end
            total++;
            if (act_o(0) !== exp_o(0)) begin
                bad++; $display("FAIL single_out k=%0d got=%h want=%h", k, act_o(0), exp_o(0));
            end
            if (k >= 1 && k <= 3) begin
                total++;
                if (cv4 !== 1'b1 || g4 !== 2'd2 || cdb4[CDB_W-1 -: RSV_ID_W] !== RSV_ID_W'(4 + k)) begin
                    bad++; $display("FAIL single_tag k=%0d got cv=%b id=%0d tag=%0d want 1/2/%0d",
                                    k, cv4, g4, cdb4[CDB_W-1 -: RSV_ID_W], 4 + k);
                end
            end
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            set_all(0, 1'b1);
            step();
            total++;
            if (act_o(0) !== exp_o(0) || obs_rdy[0] !== exp_rdy[0]) begin
                bad++; $display("FAIL contention_model j=%0d got=%h/%b want=%h/%b",
                                j, act_o(0), obs_rdy[0], exp_o(0), exp_rdy[0]);
            end
            if (j >= 1 && j <= 8) begin
                total++;
                if (cv4 !== 1'b1 || g4 !== 2'((j - 1) % 4)) begin
                    bad++; $display("FAIL contention_order j=%0d got id=%0d want %0d", j, g4, (j - 1) % 4);
                end
            end
        end
    endtask

    task automatic test_flush();
        idle(6);
        in_v[0][1] = 1'b1; in_d[0][1] = rnd_payload(33);
        in_v[0][3] = 1'b1; in_d[0][3] = rnd_payload(44);
        step();
        set_all(0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (obs_rdy[0] !== 4'b0000) begin
            bad++; $display("FAIL flush_ready got=%b want=0000", obs_rdy[0]);
        end
        total++;
        if (cv4 !== 1'b0 || b4 !== 1'b0 || act_o(0) !== exp_o(0)) begin
            bad++; $display("FAIL flush_out got=%h want=%h", act_o(0), exp_o(0));
        end
        set_all(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (cv4 !== 1'b0 || b4 !== 1'b0) begin
                bad++; $display("FAIL flush_leak k=%0d cv=%b busy=%b want 0/0", k, cv4, b4);
            end
        end
    endtask

    task automatic test_wrap();
        int want [4] = '{2, 0, 2, 0};
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        in_v[1][2] = 1'b1; in_d[1][2] = rnd_payload(12);
        step();
        for (int j = 0; j < 4; j++) begin
            in_v[1][0] = 1'b1; in_d[1][0] = rnd_payload(20 + j);
            in_v[1][2] = 1'b1; in_d[1][2] = rnd_payload(40 + j);
            step();
            total++;
            if (act_o(1) !== exp_o(1) || g3 > 2'd2) begin
                bad++; $display("FAIL wrap_model j=%0d got=%h want=%h", j, act_o(1), exp_o(1));
            end
            if (!PRIO) begin
                total++;
                if (cv3 !== 1'b1 || g3 !== 2'(want[j])) begin
                    bad++; $display("FAIL wrap_order j=%0d got=%0d want=%0d", j, g3, want[j]);
                end
            end
        end
        set_all(1, 1'b0);
    endtask

    task automatic test_prio();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 3; i++) begin
                in_v[0][i] = 1'b1; in_d[0][i] = rnd_payload(i);
            end
            step();
            if (j >= 1) begin
                total++;
                if (cv4 !== 1'b1 || g4 !== 2'd0 || act_o(0) !== exp_o(0)) begin
                    bad++; $display("FAIL prio_zero j=%0d got=%h want id 0 / %h", j, act_o(0), exp_o(0));
                end
            end
        end
        in_v[0][0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_d[0][1] = rnd_payload(1); in_d[0][2] = rnd_payload(2);
            step();
            total++;
            if (act_o(0) !== exp_o(0) || (j >= 1 && g4 !== 2'((j % 2 == 1) ? 1 : 2))) begin
                bad++; $display("FAIL prio_rr j=%0d got=%h want=%h", j, act_o(0), exp_o(0));
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            rst   = ($urandom_range(99) == 0);
            flush = ($urandom_range(19) == 0);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) begin
                    in_v[d][i] = ($urandom_range(9) < 6);
                    in_d[d][i] = rnd_payload($urandom_range(63));
                end
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_rdy[d] !== exp_rdy[d]) begin
                    bad++; $display("FAIL random_ready dut=%0d j=%0d got=%b want=%b", d, j, obs_rdy[d], exp_rdy[d]);
                end
                total++;
                if (act_o(d) !== exp_o(d)) begin
                    bad++; $display("FAIL random_out dut=%0d j=%0d got=%h want=%h", d, j, act_o(d), exp_o(d));
                end
            end
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        set_all(0, 1'b0);
        set_all(1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_hv[d][i] = 1'b0;
                m_hd[d][i] = '0;
            end
            m_ptr[d] = 0; m_cv[d] = 1'b0; m_cdb[d] = '0; m_gid[d] = 0;
        end
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_wrap();
        if (PRIO) test_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
